seg_instruction_fetch: RTL and testbench
========================================

SEG_INSTRUCTION_FETCH -- requirements
Module: seg_instruction_fetch

Interface
REQ-001 The block SHALL have parameter LEN, default 32, meaning data/instruction/PC width.
REQ-002 The block SHALL have parameter NB_MEM_ADDR, default 10, meaning instruction-memory word-address width (1024 words).
REQ-003 The block SHALL have parameter HALT_INSTR, default 32'hFFFF_FFFF, meaning the halt encoding.
REQ-004 The block SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_enable, input, 1, pipeline advance permission from the debug unit.
REQ-007 The block SHALL have port i_stall, input, 1, hazard-unit stall request.
REQ-008 The block SHALL have port i_jump, input, 1, jump taken, resolved in decode.
REQ-009 The block SHALL have port i_PC_dir_jump, input, LEN, jump target.
REQ-010 The block SHALL have port i_branch, input, 1, branch taken, resolved downstream.
REQ-011 The block SHALL have port i_PC_branch, input, LEN, branch target.
REQ-012 The block SHALL have port i_load_en, input, 1, program-load mode.
REQ-013 The block SHALL have port i_load_addr, input, NB_MEM_ADDR, word address for load.
REQ-014 The block SHALL have port i_load_data, input, LEN, instruction word to load.
REQ-015 The block SHALL have port o_PC, output, LEN, registered PC+4 of the instruction in o_instruction.
REQ-016 The block SHALL have port o_instruction, output, LEN, registered IF/ID instruction.
REQ-017 The block SHALL have port o_valid, output, 1, o_instruction is a real fetched instruction (0 = bubble).
REQ-018 The block SHALL have port o_halt, output, 1, sticky halt-fetched flag.

Function
REQ-019 The block SHALL hold a PC register and a 2^NB_MEM_ADDR x LEN instruction memory read combinationally at index PC[NB_MEM_ADDR+1:2]; PC bits above that index are ignored (address wraps).
REQ-020 The block SHALL, when i_load_en=1, write i_load_data to memory[i_load_addr] each cycle, freeze PC, and drive the IF/ID register to bubble (o_instruction=0, o_valid=0).
REQ-021 The block SHALL, when i_load_en=0 and i_enable=0, hold PC and the IF/ID register unchanged.
REQ-022 The block SHALL, when enabled, update by priority: i_branch > i_jump > halted > i_stall > sequential.
REQ-023 The block SHALL, on i_branch=1, load PC <= {i_PC_branch[LEN-1:2],2'b00} and drive the IF/ID register to bubble, overriding i_stall and i_jump.
REQ-024 The block SHALL, on i_jump=1 (no branch), load PC <= {i_PC_dir_jump[LEN-1:2],2'b00} and drive the IF/ID register to bubble, overriding i_stall.
REQ-025 The block SHALL, when halted (o_halt=1) with no redirect, hold PC and drive bubble into IF/ID.
REQ-026 The block SHALL, on i_stall=1 (no redirect, not halted), hold PC and the IF/ID register unchanged.
REQ-027 The block SHALL, on a sequential advance, latch o_instruction <= memory word, o_PC <= PC+4 (modulo 2^LEN), o_valid <= 1, PC <= PC+4.
REQ-028 The block SHALL, when a sequential advance latches a word equal to HALT_INSTR, set o_halt=1 in the same edge and keep it set until reset; the halt word is passed downstream once with o_valid=1.
REQ-029 The block SHALL provide one-cycle fetch latency: a word at PC appears on o_instruction the edge after PC is presented.
REQ-030 The block SHALL apply redirects and flushes even when i_stall=1 in the same cycle.

Reset
REQ-031 The block SHALL, while i_rst=0, immediately force PC=0, o_PC=0, o_instruction=0, o_valid=0, o_halt=0, independent of i_clk.
REQ-032 The block SHALL leave memory contents unchanged by reset, so a loaded program survives reset.
REQ-033 The block SHALL fetch memory[0] on the first enabled edge after i_rst rises.

Verification
REQ-034 The bench SHALL load words 0x2001_0005, 0x2002_0003, HALT_INSTR at 0..2, then run enabled; it SHALL expect o_instruction 0x20010005/o_PC=4, then 0x20020003/o_PC=8, then HALT_INSTR/o_PC=12 with o_halt=1, then bubbles with PC held at 12.
REQ-035 The bench SHALL assert i_stall for 2 cycles at PC=4 and expect PC=4 and the IF/ID outputs unchanged for 2 cycles, then resume at word 1.
REQ-036 The bench SHALL assert i_jump=1 with i_PC_dir_jump=0x0000_0023 and i_stall=1 and expect next PC=0x20, o_valid=0, then the word at index 8 with o_PC=0x24.
REQ-037 The bench SHALL assert i_branch=1 (target 0x40) and i_jump=1 (target 0x80) together and expect PC=0x40 and a bubble.
REQ-038 The bench SHALL drive i_rst=0 mid-run between clock edges and expect all outputs 0 immediately; after release, it SHALL expect memory[0] to be refetched, proving memory was retained.
REQ-039 The bench SHALL set PC=0xFFFF_FFFC via branch, step once, and expect o_PC=0 and fetch index 0x3FF.

Source files
------------

// File: rtl/seg_instruction_fetch.sv
// Instruction-fetch stage: PC register, loadable instruction memory and the IF/ID register.
// The fetch word is read combinationally at the current PC and latched one edge later.
module seg_instruction_fetch #(
   parameter int              LEN         = 32,
   parameter int              NB_MEM_ADDR = 10,
   parameter logic [LEN-1:0]  HALT_INSTR  = 32'hFFFF_FFFF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_stall,
   input  logic                   i_jump,
   input  logic [LEN-1:0]         i_PC_dir_jump,
   input  logic                   i_branch,
   input  logic [LEN-1:0]         i_PC_branch,
   input  logic                   i_load_en,
   input  logic [NB_MEM_ADDR-1:0] i_load_addr,
   input  logic [LEN-1:0]         i_load_data,
   output logic [LEN-1:0]         o_PC,
   output logic [LEN-1:0]         o_instruction,
   output logic                   o_valid,
   output logic                   o_halt
);

   localparam int MEM_DEPTH = 2**NB_MEM_ADDR;

   logic [LEN-1:0]         mem_q [MEM_DEPTH];
   logic [LEN-1:0]         pc_q,    pc_d;
   logic [LEN-1:0]         opc_q,   opc_d;
   logic [LEN-1:0]         instr_q, instr_d;
   logic                   valid_q, valid_d;
   logic                   halt_q,  halt_d;
   logic [NB_MEM_ADDR-1:0] fetch_idx;
   logic [LEN-1:0]         fetch_word;
   logic [LEN-1:0]         pc_plus4;
   logic                   unused_low_bits;

   // Upper PC bits beyond the word index are ignored, so fetch addresses wrap.
   assign fetch_idx       = pc_q[NB_MEM_ADDR+1:2];
   assign fetch_word      = mem_q[fetch_idx];
   assign pc_plus4        = pc_q + LEN'(4);
   assign unused_low_bits = ^{i_PC_dir_jump[1:0], i_PC_branch[1:0]};

   // Memory is deliberately outside the reset domain so a loaded program survives reset.
   always_ff @(posedge i_clk) begin
      if (i_load_en) begin
         mem_q[i_load_addr] <= i_load_data;
      end
   end

   always_comb begin
      pc_d    = pc_q;
      opc_d   = opc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      halt_d  = halt_q;
      if (i_load_en) begin
         instr_d = '0;
         valid_d = 1'b0;
      end else if (i_enable) begin
         // Redirects flush the IF/ID register and win over halt and stall.
         if (i_branch) begin
            pc_d    = {i_PC_branch[LEN-1:2], 2'b00};
            instr_d = '0;
            valid_d = 1'b0;
         end else if (i_jump) begin
            pc_d    = {i_PC_dir_jump[LEN-1:2], 2'b00};
            instr_d = '0;
            valid_d = 1'b0;
         end else if (halt_q) begin
            instr_d = '0;
            valid_d = 1'b0;
         end else if (!i_stall) begin
            pc_d    = pc_plus4;
            opc_d   = pc_plus4;
            instr_d = fetch_word;
            valid_d = 1'b1;
            if (fetch_word == HALT_INSTR) begin
               halt_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pc_q    <= '0;
         opc_q   <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         opc_q   <= opc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         halt_q  <= halt_d;
      end
   end

   assign o_PC          = opc_q;
   assign o_instruction = instr_q;
   assign o_valid       = valid_q;
   assign o_halt        = halt_q;

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// Scoreboard bench for seg_instruction_fetch: the driver queues expected IF/ID state,
// the monitor pops and compares after each clock edge or asynchronous reset assertion.
module tb_seg_instruction_fetch;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_enable;
   logic        i_stall;
   logic        i_jump;
   logic [31:0] i_PC_dir_jump;
   logic        i_branch;
   logic [31:0] i_PC_branch;
   logic        i_load_en;
   logic [9:0]  i_load_addr;
   logic [31:0] i_load_data;
   logic [31:0] o_PC;
   logic [31:0] o_instruction;
   logic        o_valid;
   logic        o_halt;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] opc;
      logic        valid;
      logic        halt;
      logic        chk_opc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   seg_instruction_fetch dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_enable      (i_enable),
      .i_stall       (i_stall),
      .i_jump        (i_jump),
      .i_PC_dir_jump (i_PC_dir_jump),
      .i_branch      (i_branch),
      .i_PC_branch   (i_PC_branch),
      .i_load_en     (i_load_en),
      .i_load_addr   (i_load_addr),
      .i_load_data   (i_load_data),
      .o_PC          (o_PC),
      .o_instruction (o_instruction),
      .o_valid       (o_valid),
      .o_halt        (o_halt)
   );

   always #5 i_clk = ~i_clk;

   task automatic push(input string n, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] opc, input logic valid, input logic halt,
                       input logic chk_opc);
      exp_t e;
      e.name = n; e.pc = pc; e.instr = instr; e.opc = opc;
      e.valid = valid; e.halt = halt; e.chk_opc = chk_opc;
      sb.push_back(e);
   endtask

   task automatic drv(input logic en, input logic st, input logic jp, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt);
      i_load_en = 1'b0; i_enable = en; i_stall = st;
      i_jump = jp; i_PC_dir_jump = jt; i_branch = br; i_PC_branch = bt;
   endtask

   task automatic ld(input logic [9:0] a, input logic [31:0] d);
      i_enable = 1'b0; i_stall = 1'b0; i_jump = 1'b0; i_branch = 1'b0;
      i_load_en = 1'b1; i_load_addr = a; i_load_data = d;
   endtask

   // Monitor: one expectation is consumed per clock edge or reset assertion.
   initial begin
      exp_t e;
      logic ok;
      forever begin
         @(posedge i_clk or negedge i_rst);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            n_tests++;
            ok = (dut.pc_q === e.pc) && (o_instruction === e.instr) &&
                 (o_valid === e.valid) && (o_halt === e.halt) &&
                 (!e.chk_opc || (o_PC === e.opc));
            if (!ok) begin
               n_fail++;
               $display("FAIL %s: got pc=%h instr=%h o_PC=%h valid=%b halt=%b; want pc=%h instr=%h o_PC=%h(chk=%b) valid=%b halt=%b",
                        e.name, dut.pc_q, o_instruction, o_PC, o_valid, o_halt,
                        e.pc, e.instr, e.opc, e.chk_opc, e.valid, e.halt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1, "timeout");
   end

   initial begin
      i_rst = 1'b1; i_enable = 1'b0; i_stall = 1'b0; i_jump = 1'b0; i_PC_dir_jump = '0;
      i_branch = 1'b0; i_PC_branch = '0; i_load_en = 1'b0; i_load_addr = '0; i_load_data = '0;
      #1;
      push("reset_init", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      i_rst = 1'b0;
      @(negedge i_clk); i_rst = 1'b1;

      // Program load: main program plus words used by the redirect tests
      @(negedge i_clk); ld(10'd0,     32'h2001_0005);
      @(negedge i_clk); ld(10'd1,     32'h2002_0003);
      @(negedge i_clk); ld(10'd2,     32'hFFFF_FFFF);
      @(negedge i_clk); ld(10'd8,     32'h2008_0008);
      @(negedge i_clk); ld(10'd16,    32'h2010_0010);
      @(negedge i_clk); ld(10'h3FF,   32'h23FF_03FF);
      push("load_bubble", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("seq_w0", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b1);
      @(negedge i_clk); drv(1, 1, 0, 0, 0, 0);
      push("stall_1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b1);
      @(negedge i_clk); drv(1, 1, 0, 0, 0, 0);
      push("stall_2", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b1);
      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("resume_w1", 32'h8, 32'h2002_0003, 32'h8, 1'b1, 1'b0, 1'b1);

      @(negedge i_clk); drv(1, 1, 1, 32'h0000_0023, 0, 0);
      push("jump_over_stall", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("after_jump_w8", 32'h24, 32'h2008_0008, 32'h24, 1'b1, 1'b0, 1'b1);

      @(negedge i_clk); drv(1, 0, 1, 32'h80, 1, 32'h40);
      push("branch_over_jump", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("after_branch_w16", 32'h44, 32'h2010_0010, 32'h44, 1'b1, 1'b0, 1'b1);

      @(negedge i_clk); drv(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
      push("branch_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("wrap_w3ff", 32'h0, 32'h23FF_03FF, 32'h0, 1'b1, 1'b0, 1'b1);

      @(negedge i_clk); drv(0, 0, 0, 0, 0, 0);
      push("disabled_hold", 32'h0, 32'h23FF_03FF, 32'h0, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset asserted between edges
      @(negedge i_clk); drv(0, 0, 0, 0, 0, 0);
      #2;
      push("reset_async", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      i_rst = 1'b0;
      @(negedge i_clk); i_rst = 1'b1; drv(1, 0, 0, 0, 0, 0);
      push("refetch_w0", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b1);
      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("prog_w1", 32'h8, 32'h2002_0003, 32'h8, 1'b1, 1'b0, 1'b1);
      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("prog_halt", 32'hC, 32'hFFFF_FFFF, 32'hC, 1'b1, 1'b1, 1'b1);
      @(negedge i_clk); drv(1, 0, 0, 0, 0, 0);
      push("halted_bubble", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      @(negedge i_clk); drv(1, 1, 0, 0, 0, 0);
      push("halted_stall", 32'hC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

      repeat (3) @(negedge i_clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
